// File: rtl/pht_write_ctrl.sv
// Write-port sequencer for the branch predictor's 2-bit-counter PHT: sweeps the table to INIT_STATE
// after reset/clear, then drains buffered branch updates. Optional build macro: PHT_UPD_COALESCE_EN.
module pht_write_ctrl #(
    parameter int         PHT_DEPTH  = 7,
    parameter logic [1:0] INIT_STATE = 2'b01,
    parameter int         QDEPTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear_req,
    input  logic                       upd_valid,
    input  logic [PHT_DEPTH-1:0]       upd_index,
    input  logic [1:0]                 upd_state,
    output logic                       upd_ready,
    input  logic                       pht_wstall,
    output logic                       pht_we,
    output logic [PHT_DEPTH-1:0]       pht_waddr,
    output logic [1:0]                 pht_wdata,
    output logic                       busy,
    output logic [$clog2(QDEPTH):0]    q_count,
    output logic [7:0]                 drop_cnt
);

    localparam int                   PW     = $clog2(QDEPTH);
    localparam logic [PW:0]          L_FULL = (PW+1)'(QDEPTH);
    localparam logic [PW:0]          L_ONE  = (PW+1)'(1);
    localparam logic [PHT_DEPTH-1:0] L_LAST = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               r_state, w_state_nxt;
    logic [PHT_DEPTH-1:0] r_sweep, w_sweep_nxt;
    logic [PHT_DEPTH-1:0] r_idx_mem [QDEPTH];
    logic [1:0]           r_st_mem  [QDEPTH];
    logic [PW-1:0]        r_wptr, r_rptr;
    logic [PW-1:0]        w_last_ptr;
    logic [PW:0]          r_count;
    logic [7:0]           r_drop;
    logic                 w_flush, w_pop, w_push, w_coal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_sweep <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        w_flush     = 1'b0;
        busy        = 1'b0;
        pht_we      = 1'b0;
        pht_waddr   = r_idx_mem[r_rptr];
        pht_wdata   = r_st_mem[r_rptr];
        case (r_state)
            ST_INIT: begin
                busy      = 1'b1;
                pht_we    = !pht_wstall;
                pht_waddr = r_sweep;
                pht_wdata = INIT_STATE;
                if (clear_req) begin
                    w_sweep_nxt = '0;
                end else if (pht_we) begin
                    // Counter wraps to 0 on the last entry, leaving it ready for the next sweep.
                    w_sweep_nxt = r_sweep + 1'b1;
                    if (r_sweep == L_LAST) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                pht_we = (r_count != '0) && !pht_wstall && !clear_req;
                if (clear_req) begin
                    w_state_nxt = ST_INIT;
                    w_sweep_nxt = '0;
                    w_flush     = 1'b1;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // upd_valid/upd_ready: an update transfers on any cycle where both are high; an update
    // presented while upd_ready is low is not held by the source, it is dropped and counted.
    assign w_pop      = (r_state == ST_RUN) && pht_we;
    assign w_last_ptr = r_wptr - 1'b1;

`ifdef PHT_UPD_COALESCE_EN
    // Newest entry is still queued unless it is the sole entry and leaves this cycle.
    assign w_coal = upd_valid && (r_state == ST_RUN) && !clear_req && (r_count != '0)
                  && (r_idx_mem[w_last_ptr] == upd_index) && !(w_pop && (r_count == L_ONE));
`else
    assign w_coal = 1'b0;
`endif

    assign upd_ready = (r_state == ST_RUN) && !clear_req && ((r_count != L_FULL) || w_coal);
    assign w_push    = upd_valid && upd_ready && !w_coal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_idx_mem[r_wptr] <= upd_index;
            r_st_mem[r_wptr]  <= upd_state;
        end else if (w_coal) begin
            r_st_mem[w_last_ptr] <= upd_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop <= '0;
        end else if (upd_valid && !upd_ready && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 1'b1;
        end
    end

    assign q_count  = r_count;
    assign drop_cnt = r_drop;

endmodule

// File: tb/tb_pht_write_ctrl.sv
// Bench for pht_write_ctrl: hand-written vector table, directed multi-cycle sequences and
// randomized traffic, all compared against a queue-based reference model of the write controller.
module tb_pht_write_ctrl;

    localparam int D = 7;
    localparam int Q = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           clear_req = 1'b0;
    logic           upd_valid = 1'b0;
    logic [D-1:0]   upd_index = '0;
    logic [1:0]     upd_state = '0;
    logic           pht_wstall = 1'b0;
    logic           upd_ready;
    logic           pht_we;
    logic [D-1:0]   pht_waddr;
    logic [1:0]     pht_wdata;
    logic           busy;
    logic [2:0]     q_count;
    logic [7:0]     drop_cnt;

    pht_write_ctrl #(.PHT_DEPTH(D), .INIT_STATE(2'b01), .QDEPTH(Q)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear_req  (clear_req),
        .upd_valid  (upd_valid),
        .upd_index  (upd_index),
        .upd_state  (upd_state),
        .upd_ready  (upd_ready),
        .pht_wstall (pht_wstall),
        .pht_we     (pht_we),
        .pht_waddr  (pht_waddr),
        .pht_wdata  (pht_wdata),
        .busy       (busy),
        .q_count    (q_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the table is either being swept (with a position) or serving a plain queue.
    typedef struct { logic [D-1:0] idx; logic [1:0] st; } ent_t;
    ent_t m_q[$];
    bit   m_init;
    int   m_sweep;
    int   m_drop;
    bit   ex_ready, ex_we, ex_coal;
    int   ex_addr, ex_data;
    int   obs_we, obs_addr, obs_data;

    function automatic void model_reset();
        m_q.delete();
        m_init  = 1'b1;
        m_sweep = 0;
        m_drop  = 0;
    endfunction

    function automatic void model_expect();
        int n;
        n = m_q.size();
        if (m_init) begin
            ex_we   = !pht_wstall;
            ex_addr = m_sweep;
            ex_data = 1;
        end else begin
            ex_we   = (n != 0) && !pht_wstall && !clear_req;
            ex_addr = (n != 0) ? int'(m_q[0].idx) : 0;
            ex_data = (n != 0) ? int'(m_q[0].st) : 0;
        end
        ex_coal = 1'b0;
`ifdef PHT_UPD_COALESCE_EN
        if (upd_valid && !m_init && !clear_req && n != 0 && m_q[n-1].idx == upd_index
            && !(ex_we && n == 1))
            ex_coal = 1'b1;
`endif
        ex_ready = !m_init && !clear_req && (n < Q || ex_coal);
    endfunction

    function automatic void model_step();
        ent_t e;
        if (upd_valid && !ex_ready && m_drop < 255) m_drop++;
        if (m_init) begin
            if (clear_req) m_sweep = 0;
            else if (ex_we) begin
                if (m_sweep == (1 << D) - 1) begin
                    m_init  = 1'b0;
                    m_sweep = 0;
                end else begin
                    m_sweep++;
                end
            end
        end else if (clear_req) begin
            m_q.delete();
            m_init  = 1'b1;
            m_sweep = 0;
        end else begin
            if (ex_we) void'(m_q.pop_front());
            if (ex_coal) begin
                e = m_q[m_q.size()-1];
                e.st = upd_state;
                m_q[m_q.size()-1] = e;
            end else if (upd_valid && ex_ready) begin
                e.idx = upd_index;
                e.st  = upd_state;
                m_q.push_back(e);
            end
        end
    endfunction

    typedef struct {
        logic clr; logic vld; logic [D-1:0] idx; logic [1:0] st; logic stall;
        logic e_ready; logic e_we; logic [D-1:0] e_addr; logic [1:0] e_data;
        logic [2:0] e_qc; logic [7:0] e_drop;
    } vec_t;

    function automatic vec_t mkv(input int clr, vld, idx, st, stall,
                                 input int r, we, addr, data, qc, drp);
        vec_t v;
        v.clr = 1'(clr); v.vld = 1'(vld); v.idx = D'(idx); v.st = 2'(st); v.stall = 1'(stall);
        v.e_ready = 1'(r); v.e_we = 1'(we); v.e_addr = D'(addr); v.e_data = 2'(data);
        v.e_qc = 3'(qc); v.e_drop = 8'(drp);
        return v;
    endfunction

    function automatic vec_t mk(input int clr, vld, idx, st, stall);
        return mkv(clr, vld, idx, st, stall, 0, 0, 0, 0, 0, 0);
    endfunction

    // One clock: drive at edge+1, compare at edge+3, then advance the model on the edge.
    task automatic tick(input vec_t v, input bit hand);
        clear_req  = v.clr;
        upd_valid  = v.vld;
        upd_index  = v.idx;
        upd_state  = v.st;
        pht_wstall = v.stall;
        #2;
        model_expect();
        chk("upd_ready", int'(upd_ready), int'(ex_ready));
        chk("pht_we", int'(pht_we), int'(ex_we));
        chk("busy", int'(busy), int'(m_init));
        chk("q_count", int'(q_count), m_q.size());
        chk("drop_cnt", int'(drop_cnt), m_drop);
        if (ex_we || m_init) chk("pht_waddr", int'(pht_waddr), ex_addr);
        if (ex_we) chk("pht_wdata", int'(pht_wdata), ex_data);
        obs_we   = int'(pht_we);
        obs_addr = int'(pht_waddr);
        obs_data = int'(pht_wdata);
        if (hand) begin
            chk("vec_ready", int'(upd_ready), int'(v.e_ready));
            chk("vec_we", int'(pht_we), int'(v.e_we));
            chk("vec_busy", int'(busy), 0);
            chk("vec_qcount", int'(q_count), int'(v.e_qc));
            chk("vec_drop", int'(drop_cnt), int'(v.e_drop));
            if (v.e_we) begin
                chk("vec_waddr", int'(pht_waddr), int'(v.e_addr));
                chk("vec_wdata", int'(pht_wdata), int'(v.e_data));
            end
        end
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        clear_req = 0; upd_valid = 0; upd_index = '0; upd_state = '0; pht_wstall = 0;
        rst = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 1);
        chk("rst_we", int'(pht_we), 1);
        chk("rst_waddr", int'(pht_waddr), 0);
        chk("rst_wdata", int'(pht_wdata), 1);
        chk("rst_ready", int'(upd_ready), 0);
        chk("rst_qcount", int'(q_count), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic sweep(input int s_lo, input int s_hi, output int n);
        n = 0;
        while (busy && n < 1000) begin
            tick(mk(0, 0, 0, 0, (n >= s_lo && n <= s_hi) ? 1 : 0), 1'b0);
            n++;
        end
    endtask

    vec_t tbl[18];
    int   n, w7, d7;

    initial begin
        // clr vld idx st stall | ready we addr data qc drop
        tbl[0]  = mkv(0, 1,  5, 2, 1,  1, 0,  0, 0, 0, 0);
        tbl[1]  = mkv(0, 1,  9, 3, 1,  1, 0,  0, 0, 1, 0);
        tbl[2]  = mkv(0, 0,  0, 0, 1,  1, 0,  0, 0, 2, 0);
        tbl[3]  = mkv(0, 0,  0, 0, 0,  1, 1,  5, 2, 2, 0);
        tbl[4]  = mkv(0, 0,  0, 0, 0,  1, 1,  9, 3, 1, 0);
        tbl[5]  = mkv(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 0);
        tbl[6]  = mkv(0, 1, 10, 0, 1,  1, 0,  0, 0, 0, 0);
        tbl[7]  = mkv(0, 1, 11, 1, 1,  1, 0,  0, 0, 1, 0);
        tbl[8]  = mkv(0, 1, 12, 2, 1,  1, 0,  0, 0, 2, 0);
        tbl[9]  = mkv(0, 1, 13, 3, 1,  1, 0,  0, 0, 3, 0);
        tbl[10] = mkv(0, 1, 14, 0, 1,  0, 0,  0, 0, 4, 0);
        tbl[11] = mkv(0, 1, 15, 1, 1,  0, 0,  0, 0, 4, 1);
        tbl[12] = mkv(0, 0,  0, 0, 1,  0, 0,  0, 0, 4, 2);
        tbl[13] = mkv(0, 1, 16, 2, 0,  0, 1, 10, 0, 4, 2);
        tbl[14] = mkv(0, 0,  0, 0, 0,  1, 1, 11, 1, 3, 3);
        tbl[15] = mkv(0, 0,  0, 0, 0,  1, 1, 12, 2, 2, 3);
        tbl[16] = mkv(0, 0,  0, 0, 0,  1, 1, 13, 3, 1, 3);
        tbl[17] = mkv(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 3);

        // Plain sweep after reset.
        do_reset();
        sweep(-1, -1, n);
        chk("sweep_len", n, 128);
        chk("ready_first_run", int'(upd_ready), 1);

        // Sweep with a five-cycle stall.
        do_reset();
        sweep(10, 14, n);
        chk("stall_sweep_len", n, 133);

        // Drain, full, drop and full-while-popping vectors.
        for (int i = 0; i < 18; i++) tick(tbl[i], 1'b1);

        // Two updates to the same index while stalled.
        tick(mk(0, 1, 7, 2, 1), 1'b0);
        tick(mk(0, 1, 7, 3, 1), 1'b0);
        #2;
`ifdef PHT_UPD_COALESCE_EN
        chk("coal_qcount", int'(q_count), 1);
`else
        chk("coal_qcount", int'(q_count), 2);
`endif
        w7 = 0;
        d7 = 0;
        for (int i = 0; i < 4; i++) begin
            tick(mk(0, 0, 0, 0, 0), 1'b0);
            if (obs_we != 0 && obs_addr == 7) begin
                w7++;
                d7 = obs_data;
            end
        end
`ifdef PHT_UPD_COALESCE_EN
        chk("coal_writes", w7, 1);
`else
        chk("coal_writes", w7, 2);
`endif
        chk("coal_last_data", d7, 3);

        // Clear with three entries queued.
        tick(mk(0, 1, 20, 2, 1), 1'b0);
        tick(mk(0, 1, 21, 3, 1), 1'b0);
        tick(mk(0, 1, 22, 0, 1), 1'b0);
        tick(mk(1, 0, 0, 0, 1), 1'b0);
        chk("clr_busy", int'(busy), 1);
        chk("clr_qcount", int'(q_count), 0);
        chk("clr_waddr", int'(pht_waddr), 0);
        sweep(-1, -1, n);
        chk("clr_sweep_len", n, 128);

        // Drop counter saturation while the sweep is held off.
        do_reset();
        for (int i = 0; i < 300; i++)
            tick(mk(0, 1, $urandom_range(0, 127), $urandom_range(0, 3), 1), 1'b0);
        chk("drop_sat", int'(drop_cnt), 255);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int stall, clr;
            stall = ($urandom_range(0, 9) < 3) ? 1 : 0;
            clr   = (stall != 0 && $urandom_range(0, 255) == 0) ? 1 : 0;
            tick(mk(clr, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3), stall),
                 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
